// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches and buffers them in a prefetch queue.
// Optional misaligned-redirect trap is compiled in with `define FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_misaligned
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = AW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]   fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]   discard_q, discard_d;
  logic [XLEN-1:0] ent_pc_q [DEPTH];
  logic [XLEN-1:0] ent_pc_d [DEPTH];
  logic [31:0]     ent_data_q [DEPTH];
  logic [31:0]     ent_data_d [DEPTH];

  logic            halt;
  logic [XLEN-1:0] redirect_tgt;
  logic [PW-1:0]   alloc_cnt;
  logic [PW-1:0]   outstanding;
  logic            req_fire;
  logic            rsp_drop;
  logic            fill_fire;
  logic            pop;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halt_q, halt_d;

  // Halt tracks the alignment of the most recent redirect target.
  always_comb begin
    halt_d = halt_q;
    if (redirect_valid) halt_d = (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halt_q <= 1'b0;
    else        halt_q <= halt_d;
  end

  assign halt             = halt_q;
  assign redirect_tgt     = redirect_pc;
  assign fetch_misaligned = halt_q;
`else
  assign halt             = 1'b0;
  assign redirect_tgt     = redirect_pc & ~XLEN'(3);
  assign fetch_misaligned = 1'b0;
`endif

  assign alloc_cnt   = alloc_ptr_q - rd_ptr_q;
  assign outstanding = alloc_ptr_q - fill_ptr_q;

  // rst_n gating keeps the request low while reset is held.
  assign mem_req_valid = rst_n && !halt && !redirect_valid && (alloc_cnt < PW'(DEPTH));
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A response with no reserved entry (stale after reset) is silently ignored.
  assign rsp_drop  = mem_rsp_valid && (discard_q != '0);
  assign fill_fire = mem_rsp_valid && (discard_q == '0) && (fill_ptr_q != alloc_ptr_q);

  assign instr_valid = (rd_ptr_q != fill_ptr_q);
  assign instr       = ent_data_q[rd_ptr_q[AW-1:0]];
  assign instr_pc    = ent_pc_q[rd_ptr_q[AW-1:0]];
  assign pop         = instr_valid && instr_ready;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    discard_d   = discard_q;
    ent_pc_d    = ent_pc_q;
    ent_data_d  = ent_data_q;

    if (req_fire) begin
      ent_pc_d[alloc_ptr_q[AW-1:0]] = fetch_pc_q;
      alloc_ptr_d = alloc_ptr_q + PW'(1);
      fetch_pc_d  = fetch_pc_q + XLEN'(4);
    end
    if (rsp_drop) discard_d = discard_q - DW'(1);
    if (fill_fire) begin
      ent_data_d[fill_ptr_q[AW-1:0]] = mem_rsp_data;
      fill_ptr_d = fill_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    // Flush after the handshake: every unanswered request becomes a pending discard.
    if (redirect_valid) begin
      fetch_pc_d  = redirect_tgt;
      discard_d   = discard_q + DW'(outstanding) - DW'(rsp_drop) - DW'(fill_fire);
      alloc_ptr_d = alloc_ptr_q;
      fill_ptr_d  = alloc_ptr_q;
      rd_ptr_d    = alloc_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      discard_q   <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      discard_q   <= discard_d;
    end
  end

  // Queue payload needs no reset: validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    ent_pc_q   <= ent_pc_d;
    ent_data_q <= ent_data_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order latency memory model plus a sequential-PC stream model.
module tb_fetch_unit;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk, rst_n;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misaligned;

  int checks, errors, cyc, lat_min, lat_max, ready_pct;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  logic        s_req_v, s_req_fire, s_pop, s_mis;
  logic [31:0] s_req_addr, s_pop_pc, s_pop_data;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock cycle of environment: memory model responds/accepts, handshakes are recorded.
  task automatic drive_cycle(input logic rv, input logic [31:0] rpc, input logic ir);
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = ir;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = memfn(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    mem_req_ready = (mq_addr.size() < DEPTH) && ($urandom_range(99) < ready_pct);
    #1;
    s_req_v    = mem_req_valid;
    s_req_fire = mem_req_valid && mem_req_ready;
    s_req_addr = mem_req_addr;
    s_pop      = instr_valid && instr_ready;
    s_pop_pc   = instr_pc;
    s_pop_data = instr;
    s_mis      = fetch_misaligned;
    if (s_req_fire) begin
      mq_addr.push_back(mem_req_addr);
      mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    mq_addr.delete(); mq_due.delete();
    lat_min = 1; lat_max = 1; ready_pct = 100;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", fetch_misaligned); end
    checks++; if (mem_req_addr !== RST_PC) begin errors++; $display("FAIL reset_req_addr: got %h expected %h", mem_req_addr, RST_PC); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_req, exp_pc;
    int first_pop;
    do_reset();
    exp_req = RST_PC; exp_pc = RST_PC; first_pop = -1;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1);
      checks++;
      if (!s_req_fire || s_req_addr !== exp_req) begin
        errors++; $display("FAIL stream_req c%0d: fire %b addr %h expected fire 1 addr %h", i, s_req_fire, s_req_addr, exp_req);
      end
      exp_req += 32'd4;
      if (s_pop) begin
        if (first_pop < 0) first_pop = i;
        checks++;
        if (s_pop_pc !== exp_pc || s_pop_data !== memfn(exp_pc)) begin
          errors++; $display("FAIL stream_pop: pc %h data %h expected pc %h data %h", s_pop_pc, s_pop_data, exp_pc, memfn(exp_pc));
        end
        exp_pc += 32'd4;
      end
      if (i >= 2) begin
        checks++; if (!s_pop) begin errors++; $display("FAIL stream_throughput c%0d: got no instr expected one", i); end
      end
    end
    checks++; if (first_pop != 2) begin errors++; $display("FAIL stream_latency: first instr cycle %0d expected 2", first_pop); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_req, exp_pc;
    int n, pops;
    logic got_req;
    do_reset();
    exp_req = RST_PC; n = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b0);
      if (s_req_fire) begin
        checks++;
        if (s_req_addr !== exp_req) begin errors++; $display("FAIL stall_req: got %h expected %h", s_req_addr, exp_req); end
        exp_req += 32'd4; n++;
      end
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL stall_count: got %0d requests expected %0d", n, DEPTH); end
    checks++; if (s_req_v !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b expected 0", s_req_v); end
    exp_pc = RST_PC; pops = 0; got_req = 1'b0;
    for (int i = 0; i < 20 && (pops < 4 || !got_req); i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1);
      if (s_pop) begin
        checks++;
        if (s_pop_pc !== exp_pc || s_pop_data !== memfn(exp_pc)) begin
          errors++; $display("FAIL stall_drain: pc %h data %h expected pc %h data %h", s_pop_pc, s_pop_data, exp_pc, memfn(exp_pc));
        end
        exp_pc += 32'd4; pops++;
      end
      if (s_req_fire && !got_req) begin
        checks++; got_req = 1'b1;
        if (s_req_addr !== 32'h10) begin errors++; $display("FAIL stall_resume: got %h expected 00000010", s_req_addr); end
      end
    end
    checks++; if (pops != 4 || !got_req) begin errors++; $display("FAIL stall_timeout: pops %0d resumed %b expected 4 and 1", pops, got_req); end
  endtask

  task automatic test_redirect_stale();
    int k;
    logic found;
    do_reset();
    lat_min = 3; lat_max = 3;
    k = 0;
    while (mq_addr.size() != 2 && k < 20) begin drive_cycle(1'b0, 32'h0, 1'b1); k++; end
    checks++; if (mq_addr.size() != 2) begin errors++; $display("FAIL stale_setup: outstanding %0d expected 2", mq_addr.size()); end
    drive_cycle(1'b1, 32'h100, 1'b1);
    checks++; if (s_req_v !== 1'b0) begin errors++; $display("FAIL stale_req_in_strobe: got %b expected 0", s_req_v); end
    drive_cycle(1'b0, 32'h0, 1'b1);
    checks++; if (!s_req_fire || s_req_addr !== 32'h100) begin errors++; $display("FAIL stale_new_req: fire %b addr %h expected 1 00000100", s_req_fire, s_req_addr); end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1);
      if (s_pop) begin
        found = 1'b1;
        checks++;
        if (s_pop_pc !== 32'h100 || s_pop_data !== memfn(32'h100)) begin
          errors++; $display("FAIL stale_first_instr: pc %h data %h expected pc 00000100 data %h", s_pop_pc, s_pop_data, memfn(32'h100));
        end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL stale_timeout: got no instr expected pc 00000100"); end
  endtask

  task automatic test_coincident();
    logic [31:0] exp_pc;
    int k, pops;
    do_reset();
    exp_pc = RST_PC; k = 0;
    while (!(mq_addr.size() > 0 && mq_due[0] <= cyc && instr_valid) && k < 20) begin
      drive_cycle(1'b0, 32'h0, 1'b1);
      if (s_pop) exp_pc += 32'd4;
      k++;
    end
    drive_cycle(1'b1, 32'h400, 1'b1);
    checks++;
    if (!s_pop || s_pop_pc !== exp_pc || s_pop_data !== memfn(exp_pc)) begin
      errors++; $display("FAIL coinc_handshake: pop %b pc %h expected pop 1 pc %h", s_pop, s_pop_pc, exp_pc);
    end
    exp_pc = 32'h400; pops = 0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1);
      if (s_pop) begin
        checks++;
        if (s_pop_pc !== exp_pc || s_pop_data !== memfn(exp_pc)) begin
          errors++; $display("FAIL coinc_stream: pc %h data %h expected pc %h data %h", s_pop_pc, s_pop_data, exp_pc, memfn(exp_pc));
        end
        exp_pc += 32'd4; pops++;
      end
    end
    checks++; if (pops != 6) begin errors++; $display("FAIL coinc_count: got %0d instrs expected 6", pops); end
  endtask

  task automatic test_wrap();
    logic [31:0] wexp [4];
    int n;
    wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    do_reset();
    drive_cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    n = 0;
    for (int i = 0; i < 8 && n < 4; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1);
      if (s_req_fire) begin
        checks++;
        if (s_req_addr !== wexp[n]) begin errors++; $display("FAIL wrap_req%0d: got %h expected %h", n, s_req_addr, wexp[n]); end
        n++;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL wrap_count: got %0d requests expected 4", n); end
  endtask

  task automatic test_misalign();
    logic found;
    do_reset();
    repeat (3) drive_cycle(1'b0, 32'h0, 1'b1);
    drive_cycle(1'b1, 32'h102, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1);
      checks++;
      if (s_mis !== 1'b1 || s_req_v !== 1'b0 || s_pop !== 1'b0) begin
        errors++; $display("FAIL mis_halt c%0d: mis %b req %b instr %b expected 1 0 0", i, s_mis, s_req_v, s_pop);
      end
    end
    drive_cycle(1'b1, 32'h106, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b1);
    checks++; if (s_mis !== 1'b1 || s_req_v !== 1'b0) begin errors++; $display("FAIL mis_rehalt: mis %b req %b expected 1 0", s_mis, s_req_v); end
    drive_cycle(1'b1, 32'h200, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b1);
    checks++;
    if (s_mis !== 1'b0 || !s_req_fire || s_req_addr !== 32'h200) begin
      errors++; $display("FAIL mis_resume: mis %b fire %b addr %h expected 0 1 00000200", s_mis, s_req_fire, s_req_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1);
      if (s_pop) begin
        found = 1'b1; checks++;
        if (s_pop_pc !== 32'h200 || s_pop_data !== memfn(32'h200)) begin
          errors++; $display("FAIL mis_first_instr: pc %h data %h expected pc 00000200 data %h", s_pop_pc, s_pop_data, memfn(32'h200));
        end
      end
    end
`else
    drive_cycle(1'b0, 32'h0, 1'b1);
    checks++;
    if (s_mis !== 1'b0 || !s_req_fire || s_req_addr !== 32'h100) begin
      errors++; $display("FAIL mis_forced: mis %b fire %b addr %h expected 0 1 00000100", s_mis, s_req_fire, s_req_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1);
      if (s_pop) begin
        found = 1'b1; checks++;
        if (s_pop_pc !== 32'h100 || s_pop_data !== memfn(32'h100)) begin
          errors++; $display("FAIL mis_first_instr: pc %h data %h expected pc 00000100 data %h", s_pop_pc, s_pop_data, memfn(32'h100));
        end
      end
    end
`endif
    checks++; if (!found) begin errors++; $display("FAIL mis_timeout: got no instr after aligned target"); end
  endtask

  task automatic test_reset_mid();
    logic found;
    do_reset();
    repeat (6) drive_cycle(1'b0, 32'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== RST_PC) begin
      errors++; $display("FAIL midreset_clear: instr_valid %b req %b addr %h expected 0 0 %h", instr_valid, mem_req_valid, mem_req_addr, RST_PC);
    end
    mq_addr.delete(); mq_due.delete();
    mq_addr.push_back(32'h0000_999C); mq_due.push_back(0);
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1; cyc = 0;
    drive_cycle(1'b0, 32'h0, 1'b1);
    checks++; if (!s_req_fire || s_req_addr !== RST_PC) begin errors++; $display("FAIL midreset_req: fire %b addr %h expected 1 %h", s_req_fire, s_req_addr, RST_PC); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1);
      if (s_pop) begin
        found = 1'b1; checks++;
        if (s_pop_pc !== RST_PC || s_pop_data !== memfn(RST_PC)) begin
          errors++; $display("FAIL midreset_first_instr: pc %h data %h expected pc %h data %h", s_pop_pc, s_pop_data, RST_PC, memfn(RST_PC));
        end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL midreset_timeout: got no instr after reset"); end
  endtask

  task automatic test_random();
    logic [31:0] exp_req, exp_pc, raw, tgt;
    logic rv;
    int pops;
    do_reset();
    lat_min = 1; lat_max = 4; ready_pct = 75;
    exp_req = RST_PC; exp_pc = RST_PC; pops = 0;
    for (int i = 0; i < 1500; i++) begin
      rv  = ($urandom_range(99) < 4);
      raw = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0003_FFFF);
`ifdef FETCH_MISALIGN_TRAP_EN
      raw = raw & ~32'h3;
`endif
      tgt = raw & ~32'h3;
      drive_cycle(rv, raw, ($urandom_range(99) < 60));
      if (rv) begin
        checks++; if (s_req_v !== 1'b0) begin errors++; $display("FAIL rand_req_in_strobe: got %b expected 0", s_req_v); end
      end
      if (s_req_fire) begin
        checks++;
        if (s_req_addr !== exp_req) begin errors++; $display("FAIL rand_req: got %h expected %h", s_req_addr, exp_req); end
        exp_req += 32'd4;
      end
      if (s_pop) begin
        checks++; pops++;
        if (s_pop_pc !== exp_pc || s_pop_data !== memfn(exp_pc)) begin
          errors++; $display("FAIL rand_pop: pc %h data %h expected pc %h data %h", s_pop_pc, s_pop_data, exp_pc, memfn(exp_pc));
        end
        exp_pc += 32'd4;
      end
      if (rv) begin exp_req = tgt; exp_pc = tgt; end
    end
    checks++; if (pops < 200) begin errors++; $display("FAIL rand_progress: got %0d instrs expected at least 200", pops); end
    checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL rand_misaligned: got %b expected 0", fetch_misaligned); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    lat_min = 1; lat_max = 1; ready_pct = 100;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stale();
    test_coincident();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
